// File: rtl/responde_memoria.sv
// Memory-side responder: answers word read/write requests over a req/ack
// handshake with a fixed, parameterised latency and flags illegal accesses.
module responde_memoria #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        pronto,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        erro
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
    $error("responde_memoria: LATENCY must be between 1 and 15");
  end

  localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);
  localparam logic [3:0]  LAT_M1  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {OCIOSO, ESPERA, RESPOSTA} estado_t;

  estado_t          estado;
  logic [3:0]       conta;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      mem [DEPTH];

  logic             acesso;
  logic             a_we;
  logic [31:0]      a_addr;
  logic [31:0]      a_wdata;
  logic             a_erro;
  logic [IDX_W-1:0] a_idx;

  // The access happens on the edge that raises ack; with LATENCY=1 that is
  // the accepting edge itself, so the live inputs are used instead of the latch.
  always_comb begin
    acesso  = 1'b0;
    a_we    = we_q;
    a_addr  = addr_q;
    a_wdata = wdata_q;
    if (LATENCY == 1) begin
      if (reset && estado == OCIOSO && req) begin
        acesso  = 1'b1;
        a_we    = we;
        a_addr  = addr;
        a_wdata = wdata;
      end
    end else if (reset && estado == ESPERA && conta == 4'd1) begin
      acesso = 1'b1;
    end
  end

  assign a_erro = (a_addr[1:0] != 2'b00) || (a_addr[31:2] >= DEPTH_W);
  assign a_idx  = a_addr[IDX_W+1:2];

  // Request latch: data only, no reset needed.
  always_ff @(posedge clock) begin
    if (estado == OCIOSO && req) begin
      we_q    <= we;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (acesso && a_we && !a_erro) mem[a_idx] <= a_wdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= OCIOSO;
      conta  <= 4'd0;
      pronto <= 1'b1;
      ack    <= 1'b0;
      erro   <= 1'b0;
      rdata  <= 32'd0;
    end else begin
      ack <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (req) begin
            pronto <= 1'b0;
            if (LATENCY == 1) begin
              estado <= RESPOSTA;
              ack    <= 1'b1;
            end else begin
              estado <= ESPERA;
              conta  <= LAT_M1;
            end
          end
        end
        ESPERA: begin
          conta <= conta - 4'd1;
          if (conta == 4'd1) begin
            estado <= RESPOSTA;
            ack    <= 1'b1;
          end
        end
        RESPOSTA: begin
          estado <= OCIOSO;
          pronto <= 1'b1;
        end
        default: begin
          estado <= OCIOSO;
          pronto <= 1'b1;
        end
      endcase
      if (acesso) begin
        erro <= a_erro;
        if (a_erro)     rdata <= 32'd0;
        else if (!a_we) rdata <= mem[a_idx];
      end
    end
  end

endmodule

// File: tb/tb_responde_memoria.sv
// Randomised bench for responde_memoria: one instance with LATENCY=2 and one
// with LATENCY=1, both checked against an array-based reference model.
module tb_responde_memoria;

  logic        clock;
  logic        reset_v [2];
  logic        req_v   [2];
  logic        we_v    [2];
  logic [31:0] addr_v  [2];
  logic [31:0] wdata_v [2];
  logic        pronto_v[2];
  logic        ack_v   [2];
  logic [31:0] rdata_v [2];
  logic        erro_v  [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tx_cnt[2];
  int ack_cnt[2];
  int ack_cyc[2];

  logic [31:0] mem_m [2][256];
  logic [31:0] last_r[2];

  responde_memoria #(.DEPTH(256), .LATENCY(2)) dut (
    .clock(clock), .reset(reset_v[0]), .req(req_v[0]), .we(we_v[0]),
    .addr(addr_v[0]), .wdata(wdata_v[0]), .pronto(pronto_v[0]),
    .ack(ack_v[0]), .rdata(rdata_v[0]), .erro(erro_v[0])
  );

  responde_memoria #(.DEPTH(256), .LATENCY(1)) dut1 (
    .clock(clock), .reset(reset_v[1]), .req(req_v[1]), .we(we_v[1]),
    .addr(addr_v[1]), .wdata(wdata_v[1]), .pronto(pronto_v[1]),
    .ack(ack_v[1]), .rdata(rdata_v[1]), .erro(erro_v[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ack must never coincide with pronto, and every ack must belong to a transaction.
  always @(negedge clock) begin
    for (int u = 0; u < 2; u++) begin
      if (ack_v[u] === 1'b1) begin
        ack_cnt[u]++;
        chk("ack_pronto_overlap", {31'd0, pronto_v[u]}, 32'd0);
      end
    end
  end

  function automatic int lat(input int u);
    return (u == 0) ? 2 : 1;
  endfunction

  // Called at a negedge; leaves the caller at the negedge where ack was seen.
  task automatic txn(input int u, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input bit hold, input bit garble);
    int k;
    bit err;
    logic [31:0] exp_r;
    we_v[u] = w; addr_v[u] = a; wdata_v[u] = d; req_v[u] = 1'b1;
    k = 0;
    while (pronto_v[u] !== 1'b1 && k < 20) begin
      @(negedge clock);
      k++;
    end
    if (k >= 20) begin
      chk("accept_timeout", 32'd1, 32'd0);
      req_v[u] = 1'b0;
      return;
    end
    @(posedge clock);
    @(negedge clock);
    k = 1;
    while (ack_v[u] !== 1'b1 && k < 20) begin
      chk("pronto_busy", {31'd0, pronto_v[u]}, 32'd0);
      if (garble) begin
        addr_v[u] = $urandom; wdata_v[u] = $urandom; we_v[u] = 1'($urandom);
        if (!hold) req_v[u] = 1'($urandom);
      end
      @(negedge clock);
      k++;
    end
    chk("latency", k, lat(u));
    ack_cyc[u] = cyc;
    tx_cnt[u]++;
    err = (a[1:0] != 2'b00) || (a[31:2] >= 30'd256);
    if (err) exp_r = 32'd0;
    else if (w) begin
      mem_m[u][a[9:2]] = d;
      exp_r = last_r[u];
    end else exp_r = mem_m[u][a[9:2]];
    last_r[u] = exp_r;
    chk("erro", {31'd0, erro_v[u]}, {31'd0, err});
    chk("rdata", rdata_v[u], exp_r);
    if (!hold) req_v[u] = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 3))
      0, 1:    a = {22'd0, 8'($urandom_range(0, 15)), 2'b00};
      2:       a = {22'd0, 8'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
      default: a = 32'h400 + ($urandom & 32'h0fff_fffc);
    endcase
    return a;
  endfunction

  int prev;

  initial begin
    for (int u = 0; u < 2; u++) begin
      reset_v[u] = 1'b1; req_v[u] = 1'b0; we_v[u] = 1'b0;
      addr_v[u] = 32'd0; wdata_v[u] = 32'd0; last_r[u] = 32'd0;
      tx_cnt[u] = 0; ack_cnt[u] = 0; ack_cyc[u] = 0;
    end
    #3;
    reset_v[0] = 1'b0; reset_v[1] = 1'b0;
    #2;
    for (int u = 0; u < 2; u++) begin
      chk("rst_pronto", {31'd0, pronto_v[u]}, 32'd1);
      chk("rst_ack",    {31'd0, ack_v[u]},    32'd0);
      chk("rst_erro",   {31'd0, erro_v[u]},   32'd0);
      chk("rst_rdata",  rdata_v[u],           32'd0);
    end
    repeat (2) @(negedge clock);
    reset_v[0] = 1'b1; reset_v[1] = 1'b1;
    @(negedge clock);

    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 16; i++) txn(u, 1'b1, 32'(i * 4), $urandom, 1'b0, 1'b0);

    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0);
    txn(0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
    chk("t1_rdata", rdata_v[0], 32'hDEADBEEF);

    txn(0, 1'b1, 32'h0, 32'd1, 1'b0, 1'b0);
    txn(0, 1'b1, 32'h4, 32'd2, 1'b0, 1'b0);
    txn(0, 1'b1, 32'h8, 32'd3, 1'b0, 1'b0);
    txn(0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    prev = ack_cyc[0];
    txn(0, 1'b0, 32'h4, 32'h0, 1'b1, 1'b0);
    chk("t2_spacing", ack_cyc[0] - prev, 32'd3);
    prev = ack_cyc[0];
    txn(0, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0);
    chk("t2_spacing", ack_cyc[0] - prev, 32'd3);
    chk("t2_rdata3", rdata_v[0], 32'd3);

    txn(0, 1'b0, 32'h6, 32'h0, 1'b0, 1'b0);
    txn(0, 1'b1, 32'h400, 32'hFFFF_FFFF, 1'b0, 1'b0);
    txn(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("t3_rdata0", rdata_v[0], 32'd1);

    txn(0, 1'b1, 32'h20, 32'h12345678, 1'b0, 1'b0);
    we_v[0] = 1'b1; addr_v[0] = 32'h20; wdata_v[0] = 32'hCAFEF00D; req_v[0] = 1'b1;
    for (int k = 0; k < 20 && pronto_v[0] !== 1'b1; k++) @(negedge clock);
    @(posedge clock);
    @(negedge clock);
    reset_v[0] = 1'b0;
    req_v[0] = 1'b0;
    #1;
    chk("t4_rst_pronto", {31'd0, pronto_v[0]}, 32'd1);
    chk("t4_rst_ack",    {31'd0, ack_v[0]},    32'd0);
    last_r[0] = 32'd0;
    @(negedge clock);
    reset_v[0] = 1'b1;
    @(negedge clock);
    txn(0, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0);
    chk("t4_rdata", rdata_v[0], 32'h12345678);

    for (int n = 0; n < 40; n++)
      txn(0, 1'($urandom), rand_addr(), $urandom, 1'($urandom), 1'b1);
    req_v[0] = 1'b0;

    txn(1, 1'b1, 32'h3C, 32'hA5A5_0001, 1'b0, 1'b0);
    txn(1, 1'b0, 32'h3C, 32'h0, 1'b0, 1'b0);
    chk("t6_rdata", rdata_v[1], 32'hA5A5_0001);
    for (int n = 0; n < 40; n++)
      txn(1, 1'($urandom), rand_addr(), $urandom, 1'($urandom), 1'b1);
    req_v[1] = 1'b0;

    repeat (4) @(negedge clock);
    chk("ack_count0", ack_cnt[0], tx_cnt[0]);
    chk("ack_count1", ack_cnt[1], tx_cnt[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
